// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled deserialiser (5-8 data bits, optional parity, 1/2 stops)
// feeding a first-word-fall-through RX FIFO, plus line-held-low configuration request detection.
module uart_receiver #(
    parameter int RX_FIFO_DEPTH = 64,
    parameter int COUNT_1MS     = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       ov_baud_rt_i,
    input  logic       rx_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] stop_bits_number_i,
    input  logic [1:0] parity_mode_i,
    input  logic       rx_fifo_read_i,
    output logic [7:0] rx_data_o,
    output logic       rx_parity_err_o,
    output logic       rx_frame_err_o,
    output logic       rx_fifo_empty_o,
    output logic       rx_fifo_full_o,
    output logic       rx_done_o,
    output logic       overrun_o,
    output logic       config_req_slv_o,
    output logic       rx_idle_o
);

    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam int CNT_W = $clog2(COUNT_1MS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t            r_state, w_state_nx;
    logic              r_rx_meta, r_rx_s;
    logic [3:0]        r_cnt_br, w_cnt_br_nx;
    logic [2:0]        r_bits, w_bits_nx;
    logic [7:0]        r_shift, w_shift_nx;
    logic              r_par_err, w_par_err_nx;
    logic              r_frm_err, w_frm_err_nx;
    logic              r_stop_cnt, w_stop_cnt_nx;
    logic [1:0]        r_width, w_width_nx;
    logic              r_two_stop, w_two_stop_nx;
    logic              r_no_par, w_no_par_nx;
    logic              r_odd, w_odd_nx;
    logic [CNT_W-1:0]  r_cnt_1ms;
    logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
    logic [9:0]        r_mem [RX_FIFO_DEPTH];

    logic              w_done;
    logic              w_break_hit;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [2:0]        w_last_idx;
    logic [9:0]        w_push_word;
    logic [9:0]        w_head;

    // Two-flop synchroniser (idle-high) and the continuous-low counter, which saturates
    // so the configuration request pulses only once per low period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_cnt_1ms <= '0;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            if (r_rx_s)
                r_cnt_1ms <= '0;
            else if (r_cnt_1ms != CNT_W'(COUNT_1MS))
                r_cnt_1ms <= r_cnt_1ms + 1'b1;
        end
    end

    assign w_break_hit = !rst_i && !r_rx_s && (r_cnt_1ms == CNT_W'(COUNT_1MS - 1));
    assign w_last_idx  = {1'b0, r_width} + 3'd4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt_br   <= '0;
            r_bits     <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_width    <= '0;
            r_two_stop <= 1'b0;
            r_no_par   <= 1'b0;
            r_odd      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt_br   <= w_cnt_br_nx;
            r_bits     <= w_bits_nx;
            r_shift    <= w_shift_nx;
            r_par_err  <= w_par_err_nx;
            r_frm_err  <= w_frm_err_nx;
            r_stop_cnt <= w_stop_cnt_nx;
            r_width    <= w_width_nx;
            r_two_stop <= w_two_stop_nx;
            r_no_par   <= w_no_par_nx;
            r_odd      <= w_odd_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_br_nx   = r_cnt_br;
        w_bits_nx     = r_bits;
        w_shift_nx    = r_shift;
        w_par_err_nx  = r_par_err;
        w_frm_err_nx  = r_frm_err;
        w_stop_cnt_nx = r_stop_cnt;
        w_width_nx    = r_width;
        w_two_stop_nx = r_two_stop;
        w_no_par_nx   = r_no_par;
        w_odd_nx      = r_odd;
        w_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s && enable_i) begin
                    w_state_nx  = ST_START;
                    w_cnt_br_nx = '0;
                end
            end
            ST_START: begin
                if (ov_baud_rt_i) begin
                    if (r_cnt_br == 4'd7) begin
                        if (r_rx_s) begin
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_state_nx    = ST_DATA;
                            w_cnt_br_nx   = '0;
                            w_bits_nx     = '0;
                            w_shift_nx    = '0;
                            w_par_err_nx  = 1'b0;
                            w_frm_err_nx  = 1'b0;
                            w_stop_cnt_nx = 1'b0;
                            w_width_nx    = data_width_i;
                            w_two_stop_nx = (stop_bits_number_i == 2'b01);
                            w_no_par_nx   = parity_mode_i[1];
                            w_odd_nx      = parity_mode_i[0];
                        end
                    end else begin
                        w_cnt_br_nx = r_cnt_br + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (ov_baud_rt_i) begin
                    w_cnt_br_nx = r_cnt_br + 1'b1;
                    if (r_cnt_br == 4'd15) begin
                        w_shift_nx[r_bits] = r_rx_s;
                        w_bits_nx          = r_bits + 1'b1;
                        if (r_bits == w_last_idx)
                            w_state_nx = r_no_par ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (ov_baud_rt_i) begin
                    w_cnt_br_nx = r_cnt_br + 1'b1;
                    if (r_cnt_br == 4'd15) begin
                        w_par_err_nx = (r_rx_s != ((^r_shift) ^ r_odd));
                        w_state_nx   = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (ov_baud_rt_i) begin
                    w_cnt_br_nx = r_cnt_br + 1'b1;
                    if (r_cnt_br == 4'd15) begin
                        if (!r_rx_s)
                            w_frm_err_nx = 1'b1;
                        if (r_two_stop && !r_stop_cnt) begin
                            w_stop_cnt_nx = 1'b1;
                        end else begin
                            w_done     = 1'b1;
                            w_state_nx = ST_IDLE;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (r_rx_s)
                    w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // A config request abandons whatever frame is in flight.
        if (w_break_hit) begin
            w_state_nx = ST_BREAK;
            w_done     = 1'b0;
        end
        if (rst_i)
            w_done = 1'b0;
    end

    assign w_push_word = {w_frm_err_nx, r_par_err, r_shift};

    // FWFT FIFO; pointers carry one extra wrap bit to separate full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = rx_fifo_read_i && !w_empty;
    assign w_push  = w_done && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i)
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_word;
    end

    assign w_head           = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign rx_data_o        = w_empty ? 8'h00 : w_head[7:0];
    assign rx_parity_err_o  = w_empty ? 1'b0  : w_head[8];
    assign rx_frame_err_o   = w_empty ? 1'b0  : w_head[9];
    assign rx_fifo_empty_o  = w_empty;
    assign rx_fifo_full_o   = w_full;
    assign rx_done_o        = w_done;
    assign overrun_o        = w_done && w_full && !w_pop;
    assign config_req_slv_o = w_break_hit;
    assign rx_idle_o        = (r_state == ST_IDLE);

endmodule
